// File: rtl/decode_stage_pkg.sv
// Shared symbols for the decode stage: instruction patterns, micro-op codes,
// register/ALU constants and FSM state encoding.
package decode_stage_pkg;

    // Word layout: {upper, op1, op2}; upper is everything above the two operand fields.
    localparam int PATTERN_UPPER_CTRL = 0;
    localparam int PATTERN_UPPER_MOV  = 1;

    // op1 field selects the class when upper == PATTERN_UPPER_CTRL.
    localparam int PATTERN_SUB_MISC = 0;
    localparam int PATTERN_SUB_ALU  = 1;
    localparam int PATTERN_SUB_LDI  = 2;
    localparam int PATTERN_SUB_LDX  = 3;
    localparam int PATTERN_SUB_STX  = 4;
    localparam int PATTERN_SUB_PUSH = 5;
    localparam int PATTERN_SUB_POP  = 6;

    // op2 field selects the operation inside the misc class.
    localparam int PATTERN_MISC_NOP  = 0;
    localparam int PATTERN_MISC_HLT  = 1;
    localparam int PATTERN_MISC_CALL = 2;
    localparam int PATTERN_MISC_RET  = 3;
    localparam int PATTERN_MISC_CMP  = 4;
    localparam int PATTERN_MISC_JMP  = 5;

    localparam int OP_NOP  = 0;
    localparam int OP_HLT  = 1;
    localparam int OP_CALL = 2;
    localparam int OP_RET  = 3;
    localparam int OP_CMP  = 4;
    localparam int OP_ALU  = 5;
    localparam int OP_LDI  = 6;
    localparam int OP_LDX  = 7;
    localparam int OP_STX  = 8;
    localparam int OP_PUSH = 9;
    localparam int OP_POP  = 10;
    localparam int OP_JMP  = 11;
    localparam int OP_MOV  = 12;

    localparam int REG_A = 0;
    localparam int REG_H = 7;

    localparam logic [2:0] ALU_SUB = 3'd1;

    typedef enum logic [0:0] {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

endpackage

// File: rtl/decode_stage_fields.sv
// Combinational field decode: instruction word -> micro-op fields.
// DECODE_ILLEGAL_TRAP_EN turns unmatched words into an OP_NOP flagged illegal.
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int RADDR_W = 3
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] opcode,
    output logic [RADDR_W-1:0] op1,
    output logic [RADDR_W-1:0] op2,
    output logic [RADDR_W-1:0] iaddr,
    output logic               iwe,
    output logic [RADDR_W-1:0] oaddr,
    output logic               ore,
    output logic [2:0]         alu_mode,
    output logic               alu_en,
    output logic               is_ldi,
    output logic               illegal
);
    localparam int UPPER_W = INSTR_W - 2 * RADDR_W;

    logic [UPPER_W-1:0] upper;
    logic               ctrl;

    assign upper = instr[INSTR_W-1:2*RADDR_W];
    assign op1   = instr[2*RADDR_W-1:RADDR_W];
    assign op2   = instr[RADDR_W-1:0];
    assign ctrl  = (upper == UPPER_W'(PATTERN_UPPER_CTRL));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        opcode   = '0;
        iaddr    = '0;
        iwe      = 1'b0;
        oaddr    = '0;
        ore      = 1'b0;
        alu_mode = '0;
        alu_en   = 1'b0;
        is_ldi   = 1'b0;
        illegal  = 1'b0;
        if (ctrl && op1 == RADDR_W'(PATTERN_SUB_MISC) && op2 == RADDR_W'(PATTERN_MISC_NOP)) begin
            opcode = INSTR_W'(OP_NOP);
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_MISC) && op2 == RADDR_W'(PATTERN_MISC_HLT)) begin
            opcode = INSTR_W'(OP_HLT);
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_MISC) && op2 == RADDR_W'(PATTERN_MISC_CALL)) begin
            opcode = INSTR_W'(OP_CALL);
            iaddr  = RADDR_W'(REG_H);
            iwe    = 1'b1;
            oaddr  = RADDR_W'(REG_H);
            ore    = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_MISC) && op2 == RADDR_W'(PATTERN_MISC_RET)) begin
            opcode = INSTR_W'(OP_RET);
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_MISC) && op2 == RADDR_W'(PATTERN_MISC_CMP)) begin
            opcode   = INSTR_W'(OP_CMP);
            alu_mode = ALU_SUB;
            alu_en   = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_ALU)) begin
            opcode   = INSTR_W'(OP_ALU);
            iaddr    = RADDR_W'(REG_A);
            iwe      = 1'b1;
            alu_mode = 3'(op2);
            alu_en   = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_LDI)) begin
            opcode = INSTR_W'(OP_LDI);
            iaddr  = op2;
            iwe    = 1'b1;
            is_ldi = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_LDX)) begin
            opcode = INSTR_W'(OP_LDX);
            iaddr  = op2;
            iwe    = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_STX)) begin
            opcode = INSTR_W'(OP_STX);
            oaddr  = op2;
            ore    = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_PUSH)) begin
            opcode = INSTR_W'(OP_PUSH);
            oaddr  = op2;
            ore    = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_POP)) begin
            opcode = INSTR_W'(OP_POP);
            iaddr  = op2;
            iwe    = 1'b1;
        end else if (ctrl && op1 == RADDR_W'(PATTERN_SUB_MISC) && op2 == RADDR_W'(PATTERN_MISC_JMP)) begin
            opcode = INSTR_W'(OP_JMP);
        end else if (upper == UPPER_W'(PATTERN_UPPER_MOV)) begin
            opcode = INSTR_W'(OP_MOV);
            iaddr  = op1;
            iwe    = 1'b1;
            oaddr  = op2;
            ore    = 1'b1;
        end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            opcode  = INSTR_W'(OP_NOP);
            illegal = 1'b1;
`else
            opcode  = instr;
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with multi-word LDI immediate assembly.
// Build option DECODE_ILLEGAL_TRAP_EN is handled inside decode_fields.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W   = 8,
    parameter int RADDR_W   = 3,
    parameter int IMM_BYTES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_W-1:0]           in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_opcode,
    output logic [RADDR_W-1:0]           out_op1,
    output logic [RADDR_W-1:0]           out_op2,
    output logic [RADDR_W-1:0]           out_iaddr,
    output logic                         out_iwe,
    output logic [RADDR_W-1:0]           out_oaddr,
    output logic                         out_ore,
    output logic [2:0]                   out_alu_mode,
    output logic                         out_alu_en,
    output logic [INSTR_W*IMM_BYTES-1:0] out_imm,
    output logic                         out_illegal
);
    localparam int IMM_W = INSTR_W * IMM_BYTES;
    localparam int CNT_W = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;

    logic [INSTR_W-1:0] d_opcode;
    logic [RADDR_W-1:0] d_op1, d_op2, d_iaddr, d_oaddr;
    logic               d_iwe, d_ore, d_alu_en, d_is_ldi, d_illegal;
    logic [2:0]         d_alu_mode;

    decode_fields #(.INSTR_W(INSTR_W), .RADDR_W(RADDR_W)) u_fields (
        .instr    (in_instr),
        .opcode   (d_opcode),
        .op1      (d_op1),
        .op2      (d_op2),
        .iaddr    (d_iaddr),
        .iwe      (d_iwe),
        .oaddr    (d_oaddr),
        .ore      (d_ore),
        .alu_mode (d_alu_mode),
        .alu_en   (d_alu_en),
        .is_ldi   (d_is_ldi),
        .illegal  (d_illegal)
    );

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [IMM_W-1:0]   imm_acc, imm_next;
    logic [RADDR_W-1:0] pend_op1, pend_op2;
    logic               out_free, last_word, accept;

    assign out_free  = !out_valid || out_ready;
    assign last_word = (state == S_IMM) && (count == CNT_W'(IMM_BYTES - 1));
    assign accept    = in_valid && in_ready;

    // Middle immediate words never touch the output register, so they need no backpressure.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            if (state == S_OP || last_word) in_ready = out_free;
            else                            in_ready = 1'b1;
        end
    end

    always_comb begin
        imm_next = imm_acc;
        for (int i = 0; i < IMM_BYTES; i++) begin
            if (count == CNT_W'(i)) imm_next[i*INSTR_W +: INSTR_W] = in_instr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pending-LDI and immediate registers are reset too, so no X ever reaches an output.
            state        <= S_OP;
            count        <= '0;
            imm_acc      <= '0;
            pend_op1     <= '0;
            pend_op2     <= '0;
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_iaddr    <= '0;
            out_iwe      <= 1'b0;
            out_oaddr    <= '0;
            out_ore      <= 1'b0;
            out_alu_mode <= '0;
            out_alu_en   <= 1'b0;
            out_imm      <= '0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            state     <= S_OP;
            count     <= '0;
            imm_acc   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (state == S_OP) begin
                    if (d_is_ldi) begin
                        state    <= S_IMM;
                        count    <= '0;
                        imm_acc  <= '0;
                        pend_op1 <= d_op1;
                        pend_op2 <= d_op2;
                    end else begin
                        out_valid    <= 1'b1;
                        out_opcode   <= d_opcode;
                        out_op1      <= d_op1;
                        out_op2      <= d_op2;
                        out_iaddr    <= d_iaddr;
                        out_iwe      <= d_iwe;
                        out_oaddr    <= d_oaddr;
                        out_ore      <= d_ore;
                        out_alu_mode <= d_alu_mode;
                        out_alu_en   <= d_alu_en;
                        out_imm      <= '0;
                        out_illegal  <= d_illegal;
                    end
                end else if (last_word) begin
                    state        <= S_OP;
                    count        <= '0;
                    out_valid    <= 1'b1;
                    out_opcode   <= INSTR_W'(OP_LDI);
                    out_op1      <= pend_op1;
                    out_op2      <= pend_op2;
                    out_iaddr    <= pend_op2;
                    out_iwe      <= 1'b1;
                    out_oaddr    <= '0;
                    out_ore      <= 1'b0;
                    out_alu_mode <= '0;
                    out_alu_en   <= 1'b0;
                    out_imm      <= imm_next;
                    out_illegal  <= 1'b0;
                end else begin
                    imm_acc <= imm_next;
                    count   <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (IMM_BYTES=2): directed steps then random
// traffic, compared each cycle against a mnemonic-level reference model.
module tb_decode_stage;
    localparam int IMM_BYTES = 2;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_instr, out_opcode;
    logic [2:0]  out_op1, out_op2, out_iaddr, out_oaddr, out_alu_mode;
    logic        out_iwe, out_ore, out_alu_en, out_illegal;
    logic [15:0] out_imm;

    decode_stage #(.INSTR_W(8), .RADDR_W(3), .IMM_BYTES(IMM_BYTES)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_op1(out_op1), .out_op2(out_op2),
        .out_iaddr(out_iaddr), .out_iwe(out_iwe),
        .out_oaddr(out_oaddr), .out_ore(out_ore),
        .out_alu_mode(out_alu_mode), .out_alu_en(out_alu_en),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {M_NOP, M_HLT, M_CALL, M_RET, M_CMP, M_ALU, M_LDI, M_LDX,
                  M_STX, M_PUSH, M_POP, M_JMP, M_MOV, M_BAD} mnem_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [2:0]  op1, op2, iaddr, oaddr, alu_mode;
        logic        iwe, ore, alu_en, illegal;
        logic [15:0] imm;
    } uop_t;

    int checks = 0;
    int failures = 0;

    // Reference model state: one held micro-op and an optional LDI in progress.
    logic        held = 1'b0;
    uop_t        held_op = '0;
    logic        ldi_pend = 1'b0;
    uop_t        ldi_op = '0;
    int          nwords = 0;
    logic [15:0] imm_buf = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assembly-level view: MOV is 01_dst_src, class 00_sub_reg, misc ops in sub 0.
    function automatic mnem_t classify(input logic [7:0] w);
        if (w[7:6] == 2'b01) return M_MOV;
        if (w[7:6] != 2'b00) return M_BAD;
        case (w[5:3])
            3'd0: case (w[2:0])
                3'd0: return M_NOP;
                3'd1: return M_HLT;
                3'd2: return M_CALL;
                3'd3: return M_RET;
                3'd4: return M_CMP;
                3'd5: return M_JMP;
                default: return M_BAD;
            endcase
            3'd1: return M_ALU;
            3'd2: return M_LDI;
            3'd3: return M_LDX;
            3'd4: return M_STX;
            3'd5: return M_PUSH;
            3'd6: return M_POP;
            default: return M_BAD;
        endcase
    endfunction

    function automatic uop_t ref_decode(input logic [7:0] w);
        uop_t  u = '0;
        mnem_t m = classify(w);
        u.op1 = w[5:3];
        u.op2 = w[2:0];
        case (m)
            M_NOP:  u.opcode = 8'd0;
            M_HLT:  u.opcode = 8'd1;
            M_CALL: begin u.opcode = 8'd2; u.iaddr = 3'd7; u.iwe = 1; u.oaddr = 3'd7; u.ore = 1; end
            M_RET:  u.opcode = 8'd3;
            M_CMP:  begin u.opcode = 8'd4; u.alu_mode = 3'd1; u.alu_en = 1; end
            M_ALU:  begin u.opcode = 8'd5; u.iaddr = 3'd0; u.iwe = 1; u.alu_mode = w[2:0]; u.alu_en = 1; end
            M_LDI:  begin u.opcode = 8'd6; u.iaddr = w[2:0]; u.iwe = 1; end
            M_LDX:  begin u.opcode = 8'd7; u.iaddr = w[2:0]; u.iwe = 1; end
            M_STX:  begin u.opcode = 8'd8; u.oaddr = w[2:0]; u.ore = 1; end
            M_PUSH: begin u.opcode = 8'd9; u.oaddr = w[2:0]; u.ore = 1; end
            M_POP:  begin u.opcode = 8'd10; u.iaddr = w[2:0]; u.iwe = 1; end
            M_JMP:  u.opcode = 8'd11;
            M_MOV:  begin u.opcode = 8'd12; u.iaddr = w[5:3]; u.iwe = 1; u.oaddr = w[2:0]; u.ore = 1; end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                u.opcode  = 8'd0;
                u.illegal = 1;
`else
                u.opcode  = w;
`endif
            end
        endcase
        return u;
    endfunction

    task automatic compare_uop(input uop_t e);
        check("opcode",   out_opcode,   e.opcode);
        check("op1",      out_op1,      e.op1);
        check("op2",      out_op2,      e.op2);
        check("iaddr",    out_iaddr,    e.iaddr);
        check("iwe",      out_iwe,      e.iwe);
        check("oaddr",    out_oaddr,    e.oaddr);
        check("ore",      out_ore,      e.ore);
        check("alu_mode", out_alu_mode, e.alu_mode);
        check("alu_en",   out_alu_en,   e.alu_en);
        check("imm",      out_imm,      e.imm);
        check("illegal",  out_illegal,  e.illegal);
    endtask

    // One clock: drive at negedge, check what the DUT presents, then advance the model.
    task automatic step(input logic r, input logic f, input logic v, input logic [7:0] w, input logic rdy);
        logic exp_ir;
        rst = r; flush = f; in_valid = v; in_instr = w; out_ready = rdy;
        #1;
        check("out_valid", out_valid, held);
        if (held) compare_uop(held_op);
        exp_ir = 1'b0;
        if (!r) begin
            if (f)                                  exp_ir = 1'b0;
            else if (ldi_pend && nwords < IMM_BYTES - 1) exp_ir = 1'b1;
            else                                    exp_ir = !held || rdy;
            check("in_ready", in_ready, exp_ir);
        end
        if (r || f) begin
            held = 0; ldi_pend = 0; nwords = 0;
        end else begin
            if (held && rdy) held = 0;
            if (v && exp_ir) begin
                if (ldi_pend) begin
                    imm_buf[nwords*8 +: 8] = w;
                    nwords++;
                    if (nwords == IMM_BYTES) begin
                        held_op = ldi_op;
                        held_op.imm = imm_buf;
                        held = 1;
                        ldi_pend = 0;
                    end
                end else if (classify(w) == M_LDI) begin
                    ldi_pend = 1; nwords = 0; imm_buf = '0;
                    ldi_op = ref_decode(w);
                end else begin
                    held_op = ref_decode(w);
                    held = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;
        rst = 1; flush = 0; in_valid = 0; in_instr = 0; out_ready = 0;
        @(negedge clk);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        check("reset_outs", {out_opcode, out_op1, out_op2, out_iaddr, out_iwe, out_oaddr,
                             out_ore, out_alu_mode, out_alu_en, out_imm, out_illegal}, 64'd0);

        // MOV r2 <- r5
        step(0, 0, 1, 8'h55, 1);
        step(0, 0, 0, 8'h00, 1);
        // ALU mode 3 then CMP back-to-back
        step(0, 0, 1, 8'h0B, 1);
        step(0, 0, 1, 8'h04, 1);
        step(0, 0, 0, 8'h00, 1);
        // LDI r4, imm 0x1234 over two words
        step(0, 0, 1, 8'h14, 1);
        step(0, 0, 1, 8'h34, 1);
        step(0, 0, 1, 8'h12, 1);
        check("ldi_imm", out_imm, 16'h1234);
        step(0, 0, 0, 8'h00, 1);
        // PUSH held under backpressure while CALL waits, then released
        step(0, 0, 1, 8'h29, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h02, 0);
        step(0, 0, 1, 8'h02, 1);
        step(0, 0, 0, 8'h00, 1);
        // Flush after LDI opcode: presented word is dropped, MOV decodes normally
        step(0, 0, 1, 8'h14, 1);
        step(0, 1, 1, 8'h34, 1);
        step(0, 0, 1, 8'h55, 1);
        step(0, 0, 0, 8'h00, 1);
        // Unmatched encodings
        step(0, 0, 1, 8'h80, 1);
        step(0, 0, 1, 8'h07, 1);
        step(0, 0, 0, 8'h00, 1);
        // Reset mid-LDI, then reset and flush together with an op held
        step(0, 0, 1, 8'h11, 1);
        step(1, 0, 1, 8'h77, 1);
        step(0, 0, 1, 8'h4A, 1);
        step(0, 0, 0, 8'h00, 0);
        step(1, 1, 1, 8'h29, 0);
        step(0, 0, 0, 8'h00, 1);

        // Random traffic biased toward legal control-class words and LDI
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    w = 8'h10 | 8'($urandom_range(0, 7));
                2:       w = 8'($urandom_range(0, 255));
                default: w = 8'($urandom_range(0, 127));
            endcase
            step(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), w,
                 ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage. It replaces the purely combinational decoder between fetch and the register file/ALU.
- Generalised in instruction width and immediate length.
- Multi-byte instructions (LDI plus immediate bytes) are assembled internally.
- Emits one fully decoded micro-op per instruction, with explicit read/write enables instead of don't-care addresses.

Parameters:
- INSTR_W, 8, instruction/opcode width in bits (>=8).
- RADDR_W, 3, register address width. Operand fields are instruction[2*RADDR_W-1:RADDR_W] and [RADDR_W-1:0].
- IMM_BYTES, 1, number of INSTR_W-wide immediate words following an LDI opcode (1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard partial/held instruction (branch redirect)
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage accepts word this cycle
- in_instr  in  INSTR_W  fetch word
- out_valid  out  1  decoded micro-op valid
- out_ready  in  1  downstream accepts micro-op
- out_opcode  out  INSTR_W  OP_* code
- out_op1  out  RADDR_W  operand1 field
- out_op2  out  RADDR_W  operand2 field
- out_iaddr  out  RADDR_W  register write address
- out_iwe  out  1  out_iaddr meaningful (register write)
- out_oaddr  out  RADDR_W  register read address
- out_ore  out  1  out_oaddr meaningful
- out_alu_mode  out  3  ALU mode
- out_alu_en  out  1  ALU used
- out_imm  out  INSTR_W*IMM_BYTES  assembled immediate, first word in LSBs
- out_illegal  out  1  see Optional Feature

Behaviour:
- Reset: all out_* registers 0, out_valid=0, state=S_OP, immediate count=0. in_ready is combinational.
- FSM states:
  - S_OP: in_ready = !out_valid || out_ready. On accept, decode with the PATTERN_* priority order NOP, HLT, CALL, RET, CMP, ALU, LDI, LDX, STX, PUSH, POP, JMP, MOV.
    - Non-LDI: load output register; out_valid=1 next cycle (latency 1).
    - LDI: latch opcode/fields, go to S_IMM, count=0.
  - S_IMM: in_ready = 1. Each accepted word is written to imm slice [count]. On the last word (count==IMM_BYTES-1), load the output register and return to S_OP. The output register is guaranteed free because entry to S_IMM required it to drain or be consumed.
    - Amended rule: S_IMM in_ready = !out_valid || out_ready on the last word only.
- Output hold: while out_valid && !out_ready, all out_* are stable. Accept-and-load in the same cycle as the downstream takes the previous op is allowed (full throughput, 1 op/cycle).
- Field rules:
  - iaddr/iwe: ALU→REG_A; CALL→REG_H; LDX, LDI, POP→op2; MOV→op1. Otherwise iwe=0, iaddr=0.
  - oaddr/ore: CALL→REG_H; MOV, STX, PUSH→op2. Otherwise ore=0, oaddr=0.
  - alu_mode/alu_en: ALU→op2 (low 3 bits); CMP→ALU_SUB. Otherwise alu_en=0, alu_mode=0.
  - out_imm is 0 for non-LDI ops.
- No X is ever driven on any output.
- flush: highest priority below rst. Clears out_valid, returns to S_OP, count=0, discards partial LDI. in_ready=0 during a flush cycle; a word presented then is dropped.
- Simultaneous rst and flush: rst wins (identical end state).
- Reset mid-LDI: partial immediate discarded.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: a word matching no PATTERN_* yields out_opcode=OP_NOP, out_illegal=1, all enables 0, and is still emitted as a micro-op (single cycle, normal handshake).
- Undefined: legacy pass-through, out_opcode=in_instr, out_illegal tied 0.

Decomposition:
- PATTERN_*, OP_*, ALU_*, REG_* constants and state encodings (S_OP, S_IMM) live in the shared symbols include.
- Combinational field decode is sub-module decode_fields (instruction→opcode/iaddr/iwe/oaddr/ore/alu fields, INSTR_W/RADDR_W params). decode_stage adds FSM, immediate assembly and the output register.

Test Plan:
- MOV op1=2, op2=5, out_ready=1 → one cycle later out_valid=1, opcode=OP_MOV, iaddr=2, iwe=1, oaddr=5, ore=1, alu_en=0.
- ALU with op2=3'b011 then CMP back-to-back, out_ready=1 → two consecutive valid ops: alu_mode=3 with iaddr=REG_A and iwe=1, then alu_mode=ALU_SUB with iwe=0. in_ready never drops.
- IMM_BYTES=2: LDI op2=4, then 0x34, then 0x12 → single op with imm=0x1234, iaddr=4, iwe=1. No out_valid during the two middle cycles.
- out_ready=0 for 5 cycles with a PUSH held → outputs stable, in_ready=0 in S_OP. On release, the next queued CALL is accepted in the same cycle.
- flush after LDI opcode byte, then MOV → no LDI emitted; MOV decoded normally.
- Unknown encoding: with DECODE_ILLEGAL_TRAP_EN → opcode=OP_NOP, illegal=1; without → opcode equals the input word.
